uart_rx_massiv_parser: RTL and testbench

Receive-side counterpart of the block-transfer UART transmitter. Deserialises 8N1 bytes on `rx` and locks onto the frame `0x23 0x0A 0x3A`. It then reassembles N_WORDS big-endian 16-bit words and checks the trailing 16-bit additive checksum. Sits at the capture end of the serial link and feeds reassembled words to a sink that must accept one word per `word_valid` pulse.

---
 rtl/uart_massiv_pkg.sv | 40 ++++
 rtl/uart_rx_massiv_parser_if.sv | 18 +
 rtl/uart_rx.sv | 117 +++++++++++
 rtl/uart_rx_massiv_parser.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_massiv_parser.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_massiv_pkg.sv
// Shared definitions for the block-transfer UART link: frame header bytes,
// parser/receiver state encodings, error codes and the default frame length.
package uart_massiv_pkg;

   localparam logic [7:0] HDR_BYTE0 = 8'h23;
   localparam logic [7:0] HDR_BYTE1 = 8'h0A;
   localparam logic [7:0] HDR_BYTE2 = 8'h3A;

   localparam int DEFAULT_N_WORDS = 1025;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR1,
      ST_HDR2,
      ST_DATA_HI,
      ST_DATA_LO,
      ST_CRC_HI,
      ST_CRC_LO
   } parser_state_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_STOP     = 2'd1,
      ERR_TIMEOUT  = 2'd2,
      ERR_CHECKSUM = 2'd3
   } err_code_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   // Additive checksum step; carries out of bit 15 are dropped.
   function automatic logic [15:0] sum16(input logic [15:0] acc, input logic [15:0] word);
      return acc + word;
   endfunction

endpackage

// File: rtl/uart_rx_massiv_parser_if.sv
// Word/frame output bundle of the massiv frame parser toward its sink.
interface uart_rx_massiv_parser_if;
   logic [15:0] word_data;
   logic        word_valid;
   logic [10:0] word_index;
   logic        frame_ok;
   logic        frame_err;
   logic [1:0]  err_code;
   logic        busy;

   modport master (
      output word_data, word_valid, word_index, frame_ok, frame_err, err_code, busy
   );

   modport slave (
      input word_data, word_valid, word_index, frame_ok, frame_err, err_code, busy
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 byte receiver: synchronises rx, samples bits at their centres and
// reports each byte with either a byte_valid or a byte_ferr pulse.
module uart_rx
   import uart_massiv_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data,
   output logic       byte_valid,
   output logic       byte_ferr
);

   localparam int             CW      = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]  FULL_M1 = CW'(CLKS_PER_BIT - 1);

   logic [1:0]    sync_reg;
   logic          rx_prev_reg;
   logic          rx_s;
   logic          fall;

   rx_state_t     state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [2:0]    bit_idx_reg, bit_idx_next;
   logic          valid_reg, valid_next;
   logic          ferr_reg, ferr_next;
   logic          sample_data;
   logic [7:0]    bit_en;
   logic [7:0]    data_reg;

   assign rx_s = sync_reg[1];
   assign fall = rx_prev_reg & ~rx_s;

   // Synchroniser idles high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg    <= 2'b11;
         rx_prev_reg <= 1'b1;
      end else begin
         sync_reg    <= {sync_reg[0], rx};
         rx_prev_reg <= rx_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= RX_IDLE;
         cnt_reg     <= '0;
         bit_idx_reg <= '0;
         valid_reg   <= 1'b0;
         ferr_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         bit_idx_reg <= bit_idx_next;
         valid_reg   <= valid_next;
         ferr_reg    <= ferr_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg + 1'b1;
      bit_idx_next = bit_idx_reg;
      valid_next   = 1'b0;
      ferr_next    = 1'b0;
      sample_data  = 1'b0;
      case (state_reg)
         RX_IDLE: begin
            cnt_next = '0;
            if (fall) state_next = RX_START;
         end
         RX_START: begin
            if (cnt_reg == HALF_M1) begin
               cnt_next     = '0;
               bit_idx_next = '0;
               // A glitch that is gone by mid start bit is dropped silently.
               state_next   = rx_s ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt_reg == FULL_M1) begin
               cnt_next    = '0;
               sample_data = 1'b1;
               if (bit_idx_reg == 3'd7) state_next = RX_STOP;
               else                     bit_idx_next = bit_idx_reg + 3'd1;
            end
         end
         RX_STOP: begin
            if (cnt_reg == FULL_M1) begin
               cnt_next   = '0;
               valid_next = rx_s;
               ferr_next  = ~rx_s;
               state_next = RX_IDLE;
            end
         end
         default: state_next = RX_IDLE;
      endcase
   end

   for (genvar gi = 0; gi < 8; gi++) begin : g_bit_en
      assign bit_en[gi] = sample_data && (bit_idx_reg == 3'(gi));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_reg <= '0;
      else        data_reg <= (data_reg & ~bit_en) | (bit_en & {8{rx_s}});
   end

   assign data       = data_reg;
   assign byte_valid = valid_reg;
   assign byte_ferr  = ferr_reg;

endmodule

// File: rtl/uart_rx_massiv_parser.sv
// Frame parser: locks onto 0x23 0x0A 0x3A, emits N_WORDS big-endian words
// and verifies the trailing 16-bit additive checksum.
module uart_rx_massiv_parser
   import uart_massiv_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int N_WORDS      = DEFAULT_N_WORDS,
   parameter int TIMEOUT_CYC  = 100000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rx,
   uart_rx_massiv_parser_if.master   wif
);

   localparam int             TW      = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0]  TMO_M1  = TW'(TIMEOUT_CYC - 1);
   localparam logic [10:0]    LAST_IX = 11'(N_WORDS - 1);

   logic [7:0]    rx_data;
   logic          byte_valid;
   logic          byte_ferr;
   logic [15:0]   rx_word;

   parser_state_t state_reg, state_next;
   logic [7:0]    hi_reg, hi_next;
   logic [10:0]   count_reg, count_next;
   logic [15:0]   sum_reg, sum_next;
   logic [TW-1:0] tmo_reg, tmo_next;
   logic [15:0]   word_data_reg, word_data_next;
   logic [10:0]   word_index_reg, word_index_next;
   logic          word_valid_reg, word_valid_next;
   logic          frame_ok_reg, frame_ok_next;
   logic          frame_err_reg, frame_err_next;
   err_code_t     err_code_reg, err_code_next;

   uart_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .data       (rx_data),
      .byte_valid (byte_valid),
      .byte_ferr  (byte_ferr)
   );

   assign rx_word = {hi_reg, rx_data};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         hi_reg         <= '0;
         count_reg      <= '0;
         sum_reg        <= '0;
         tmo_reg        <= '0;
         word_data_reg  <= '0;
         word_index_reg <= '0;
         word_valid_reg <= 1'b0;
         frame_ok_reg   <= 1'b0;
         frame_err_reg  <= 1'b0;
         err_code_reg   <= ERR_NONE;
      end else begin
         state_reg      <= state_next;
         hi_reg         <= hi_next;
         count_reg      <= count_next;
         sum_reg        <= sum_next;
         tmo_reg        <= tmo_next;
         word_data_reg  <= word_data_next;
         word_index_reg <= word_index_next;
         word_valid_reg <= word_valid_next;
         frame_ok_reg   <= frame_ok_next;
         frame_err_reg  <= frame_err_next;
         err_code_reg   <= err_code_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      hi_next         = hi_reg;
      count_next      = count_reg;
      sum_next        = sum_reg;
      tmo_next        = (state_reg == ST_IDLE) ? '0 : tmo_reg + 1'b1;
      word_data_next  = word_data_reg;
      word_index_next = word_index_reg;
      word_valid_next = 1'b0;
      frame_ok_next   = 1'b0;
      frame_err_next  = 1'b0;
      err_code_next   = err_code_reg;

      // A byte arriving in the timeout cycle takes priority and restarts the count.
      if (byte_valid) begin
         tmo_next = '0;
         case (state_reg)
            ST_IDLE: begin
               if (rx_data == HDR_BYTE0) state_next = ST_HDR1;
            end
            ST_HDR1: begin
               if      (rx_data == HDR_BYTE1) state_next = ST_HDR2;
               else if (rx_data == HDR_BYTE0) state_next = ST_HDR1;
               else                           state_next = ST_IDLE;
            end
            ST_HDR2: begin
               if (rx_data == HDR_BYTE2) begin
                  state_next = ST_DATA_HI;
                  count_next = '0;
                  sum_next   = '0;
               end else if (rx_data == HDR_BYTE0) begin
                  state_next = ST_HDR1;
               end else begin
                  state_next = ST_IDLE;
               end
            end
            ST_DATA_HI: begin
               hi_next    = rx_data;
               state_next = ST_DATA_LO;
            end
            ST_DATA_LO: begin
               word_data_next  = rx_word;
               word_index_next = count_reg;
               word_valid_next = 1'b1;
               sum_next        = sum16(sum_reg, rx_word);
               if (count_reg == LAST_IX) begin
                  state_next = ST_CRC_HI;
               end else begin
                  count_next = count_reg + 11'd1;
                  state_next = ST_DATA_HI;
               end
            end
            ST_CRC_HI: begin
               hi_next    = rx_data;
               state_next = ST_CRC_LO;
            end
            ST_CRC_LO: begin
               if (rx_word == sum_reg) begin
                  frame_ok_next = 1'b1;
               end else begin
                  frame_err_next = 1'b1;
                  err_code_next  = ERR_CHECKSUM;
               end
               state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
         endcase
      end else if (byte_ferr && state_reg != ST_IDLE) begin
         frame_err_next = 1'b1;
         err_code_next  = ERR_STOP;
         state_next     = ST_IDLE;
      end else if (state_reg != ST_IDLE && tmo_reg == TMO_M1) begin
         frame_err_next = 1'b1;
         err_code_next  = ERR_TIMEOUT;
         state_next     = ST_IDLE;
      end
   end

   assign wif.word_data  = word_data_reg;
   assign wif.word_valid = word_valid_reg;
   assign wif.word_index = word_index_reg;
   assign wif.frame_ok   = frame_ok_reg;
   assign wif.frame_err  = frame_err_reg;
   assign wif.err_code   = err_code_reg;
   assign wif.busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_massiv_parser.sv
// Directed bench: a 4-word parser and a full 1025-word parser share one rx line.
module tb_uart_rx_massiv_parser;

   localparam int CPB = 3;
   localparam int TMO = 1000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx = 1'b1;

   int n_tests = 0;
   int n_fail  = 0;

   logic [26:0] qa[$];
   logic [26:0] qb[$];
   int a_ok = 0, a_err = 0, b_ok = 0, b_err = 0, excl_viol = 0;

   uart_rx_massiv_parser_if if_a();
   uart_rx_massiv_parser_if if_b();

   uart_rx_massiv_parser #(
      .CLKS_PER_BIT (CPB),
      .N_WORDS      (4),
      .TIMEOUT_CYC  (TMO)
   ) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .rx    (rx),
      .wif   (if_a)
   );

   uart_rx_massiv_parser #(
      .CLKS_PER_BIT (CPB),
      .N_WORDS      (1025),
      .TIMEOUT_CYC  (TMO)
   ) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .rx    (rx),
      .wif   (if_b)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (if_a.word_valid) qa.push_back({if_a.word_index, if_a.word_data});
      if (if_a.frame_ok)   a_ok++;
      if (if_a.frame_err)  a_err++;
      if (int'(if_a.word_valid) + int'(if_a.frame_ok) + int'(if_a.frame_err) > 1) excl_viol++;
      if (if_b.word_valid) qb.push_back({if_b.word_index, if_b.word_data});
      if (if_b.frame_ok)   b_ok++;
      if (if_b.frame_err)  b_err++;
      if (int'(if_b.word_valid) + int'(if_b.frame_ok) + int'(if_b.frame_err) > 1) excl_viol++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = stop;
      tick(CPB);
      rx = 1'b1;
      if (!stop) tick(CPB);
   endtask

   task automatic send_word(input logic [15:0] w);
      send_byte(w[15:8], 1'b1);
      send_byte(w[7:0], 1'b1);
   endtask

   task automatic send_hdr();
      send_byte(8'h23, 1'b1);
      send_byte(8'h0A, 1'b1);
      send_byte(8'h3A, 1'b1);
   endtask

   task automatic send_payload4(input logic [15:0] crc);
      send_word(16'h1234);
      send_word(16'hABCD);
      send_word(16'h0001);
      send_word(16'hFFFF);
      send_word(crc);
   endtask

   task automatic clear_logs();
      qa.delete();
      qb.delete();
      a_ok = 0; a_err = 0; b_ok = 0; b_err = 0;
   endtask

   task automatic chk_words4(input string tag);
      logic [15:0] exp_w [4];
      exp_w = '{16'h1234, 16'hABCD, 16'h0001, 16'hFFFF};
      chk({tag, "_count"}, 32'(qa.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         chk({tag, "_word"}, (i < qa.size()) ? 32'(qa[i]) : 32'hDEADBEEF,
             {5'b0, 11'(i), exp_w[i]});
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_a"}, {if_a.word_data, if_a.word_index, if_a.word_valid, if_a.frame_ok,
                        if_a.frame_err, if_a.err_code, if_a.busy}, 32'd0);
      chk({tag, "_b"}, {if_b.word_data, if_b.word_index, if_b.word_valid, if_b.frame_ok,
                        if_b.frame_err, if_b.err_code, if_b.busy}, 32'd0);
   endtask

   initial begin
      logic [15:0] big_sum;

      // Reset state
      tick(4);
      chk_outputs_zero("reset");
      rst_n = 1'b1;
      tick(4);
      clear_logs();
      $display("[TB] reset released");

      // Good frame
      send_hdr();
      send_payload4(16'hBE01);
      tick(10);
      chk_words4("good");
      chk("good_ok", 32'(a_ok), 32'd1);
      chk("good_err", 32'(a_err), 32'd0);
      chk("good_busy", 32'(if_a.busy), 32'd0);
      $display("[TB] good frame: words=%0d ok=%0d err=%0d", qa.size(), a_ok, a_err);
      clear_logs();

      // Bad checksum
      send_hdr();
      send_payload4(16'hBE02);
      tick(10);
      chk_words4("badsum");
      chk("badsum_ok", 32'(a_ok), 32'd0);
      chk("badsum_err", 32'(a_err), 32'd1);
      chk("badsum_code", 32'(if_a.err_code), 32'd3);
      $display("[TB] bad checksum frame: words=%0d err=%0d code=%0d", qa.size(), a_err, if_a.err_code);
      clear_logs();

      // Header resync
      send_byte(8'h55, 1'b1);
      send_byte(8'h23, 1'b1);
      send_hdr();
      send_payload4(16'hBE01);
      tick(10);
      chk_words4("resync");
      chk("resync_ok", 32'(a_ok), 32'd1);
      chk("resync_err", 32'(a_err), 32'd0);
      $display("[TB] resync frame: words=%0d ok=%0d", qa.size(), a_ok);
      clear_logs();

      send_byte(8'h23, 1'b1);
      tick(6);
      chk("hdr_busy_hi", 32'(if_a.busy), 32'd1);
      send_byte(8'h0B, 1'b1);
      tick(6);
      chk("hdr_busy_lo", 32'(if_a.busy), 32'd0);
      chk("hdr_silent", 32'(a_err + a_ok + qa.size()), 32'd0);
      $display("[TB] broken header 0x23 0x0B: busy=%0d", if_a.busy);
      clear_logs();

      // Stop-bit error on the 3rd data byte, then a good frame
      send_hdr();
      send_word(16'h1234);
      send_byte(8'hAB, 1'b0);
      tick(10);
      chk("ferr_words", 32'(qa.size()), 32'd1);
      chk("ferr_err", 32'(a_err), 32'd1);
      chk("ferr_code", 32'(if_a.err_code), 32'd1);
      chk("ferr_busy", 32'(if_a.busy), 32'd0);
      $display("[TB] stop-bit error frame: err=%0d code=%0d", a_err, if_a.err_code);
      clear_logs();
      send_hdr();
      send_payload4(16'hBE01);
      tick(10);
      chk_words4("after_ferr");
      chk("after_ferr_ok", 32'(a_ok), 32'd1);
      chk("after_ferr_err", 32'(a_err), 32'd0);
      $display("[TB] frame after stop-bit error: ok=%0d", a_ok);
      clear_logs();

      // Timeout after the 2nd word
      send_hdr();
      send_word(16'h1234);
      send_word(16'hABCD);
      tick(TMO + 100);
      chk("tmo_words", 32'(qa.size()), 32'd2);
      chk("tmo_err", 32'(a_err), 32'd1);
      chk("tmo_code", 32'(if_a.err_code), 32'd2);
      chk("tmo_busy", 32'(if_a.busy), 32'd0);
      chk("tmo_ok", 32'(a_ok), 32'd0);
      $display("[TB] timeout frame: err=%0d code=%0d busy=%0d", a_err, if_a.err_code, if_a.busy);

      // Reset mid-word
      send_hdr();
      send_byte(8'h12, 1'b1);
      rx = 1'b0;
      tick(CPB * 3);
      rst_n = 1'b0;
      tick(2);
      chk_outputs_zero("midreset");
      clear_logs();
      tick(3);
      rx = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(CPB * 12);
      chk("midreset_pulses", 32'(a_ok + a_err + b_ok + b_err + qa.size() + qb.size()), 32'd0);
      chk("midreset_busy", {31'd0, if_a.busy | if_b.busy}, 32'd0);
      $display("[TB] reset mid-word: outputs cleared");

      // Full-length frame, incrementing words
      big_sum = 16'h0000;
      send_hdr();
      for (int i = 0; i < 1025; i++) begin
         send_word(16'(i));
         big_sum = big_sum + 16'(i);
      end
      send_word(big_sum);
      tick(10);
      chk("big_count", 32'(qb.size()), 32'd1025);
      for (int i = 0; i < 1025; i++)
         chk("big_word", (i < qb.size()) ? 32'(qb[i]) : 32'hDEADBEEF, {5'b0, 11'(i), 16'(i)});
      chk("big_ok", 32'(b_ok), 32'd1);
      chk("big_err", 32'(b_err), 32'd0);
      $display("[TB] 1025-word frame: words=%0d ok=%0d err=%0d", qb.size(), b_ok, b_err);

      chk("pulse_exclusive", 32'(excl_viol), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
